// File: rtl/alu_seq.sv
// Sequential ALU with valid/ready handshake: IDLE -> (BUSY) -> DONE -> IDLE.
// Define ALU_SEQ_MULDIV_EN to enable iterative MUL/DIV (one bit per cycle); otherwise opcodes 5/6 are illegal.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       alu_op,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ans,
  output logic [WIDTH-1:0] ans_hi,
  output logic             c_out,
  output logic             ac_out,
  output logic             ov_out,
  output logic             err
);
  localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDC = 5'd1,  OP_INC = 5'd2,  OP_DEC  = 5'd3,
                         OP_SUBB = 5'd4,  OP_MUL  = 5'd5,  OP_DIV = 5'd6,  OP_ANL  = 5'd8,
                         OP_ORL  = 5'd9,  OP_XRL  = 5'd10, OP_CLR = 5'd11, OP_CPL  = 5'd12,
                         OP_SWAP = 5'd13, OP_RL   = 5'd14, OP_RLC = 5'd15, OP_RR   = 5'd16,
                         OP_RRC  = 5'd17;
  localparam int HW = WIDTH / 2;

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             c;
    logic             ac;
    logic             ov;
    logic             err;
  } rsp_t;

`ifdef ALU_SEQ_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_t;
`endif

  state_t         state;
  rsp_t           rsp_q, rsp_1c;
  logic           cy;
  logic [WIDTH:0] ax, bx, add_s, sub_d;

  // Single-cycle datapath, evaluated on the accepted inputs.
  always_comb begin
    cy     = (alu_op == OP_ADDC) ? c_in : 1'b0;
    ax     = {1'b0, a_data};
    bx     = {1'b0, b_data};
    add_s  = ax + bx + {{WIDTH{1'b0}}, cy};
    sub_d  = ax - bx - {{WIDTH{1'b0}}, c_in};
    rsp_1c = '0;
    case (alu_op)
      OP_ADD, OP_ADDC: begin
        rsp_1c.lo = add_s[WIDTH-1:0];
        rsp_1c.c  = add_s[WIDTH];
        // carry into bit k recovered as a^b^sum at bit k
        rsp_1c.ac = ax[4] ^ bx[4] ^ add_s[4];
        rsp_1c.ov = ax[WIDTH-1] ^ bx[WIDTH-1] ^ add_s[WIDTH-1] ^ add_s[WIDTH];
      end
      OP_SUBB: begin
        rsp_1c.lo = sub_d[WIDTH-1:0];
        rsp_1c.c  = sub_d[WIDTH];
        rsp_1c.ac = ax[4] ^ bx[4] ^ sub_d[4];
        rsp_1c.ov = ax[WIDTH-1] ^ bx[WIDTH-1] ^ sub_d[WIDTH-1] ^ sub_d[WIDTH];
      end
      OP_INC:  rsp_1c.lo = a_data + 1'b1;
      OP_DEC:  rsp_1c.lo = a_data - 1'b1;
      OP_ANL:  rsp_1c.lo = a_data & b_data;
      OP_ORL:  rsp_1c.lo = a_data | b_data;
      OP_XRL:  rsp_1c.lo = a_data ^ b_data;
      OP_CLR:  rsp_1c.lo = '0;
      OP_CPL:  rsp_1c.lo = ~a_data;
      OP_SWAP: rsp_1c.lo = {a_data[HW-1:0], a_data[WIDTH-1:HW]};
      OP_RL:   rsp_1c.lo = {a_data[WIDTH-2:0], a_data[WIDTH-1]};
      OP_RR:   rsp_1c.lo = {a_data[0], a_data[WIDTH-1:1]};
      OP_RLC: begin
        rsp_1c.lo = {a_data[WIDTH-2:0], c_in};
        rsp_1c.c  = a_data[WIDTH-1];
      end
      OP_RRC: begin
        rsp_1c.lo = {c_in, a_data[WIDTH-1:1]};
        rsp_1c.c  = a_data[0];
      end
`ifdef ALU_SEQ_MULDIV_EN
      OP_MUL: rsp_1c = '0;
      OP_DIV: begin
        // only used for b=0; nonzero divisors go through BUSY
        rsp_1c.lo = '1;
        rsp_1c.hi = a_data;
        rsp_1c.ov = 1'b1;
      end
`endif
      default: rsp_1c.err = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MULDIV_EN
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] opnd, w_hi, w_lo, nhi, nlo, rdiff;
  logic [WIDTH:0]   msum, rsh;
  logic [CW-1:0]    cnt;
  logic             is_div, ge, iter_go;

  // MUL: shift-add, {w_hi,w_lo} shifts right. DIV: restoring, w_hi=remainder, w_lo=quotient.
  always_comb begin
    iter_go = (alu_op == OP_MUL) || ((alu_op == OP_DIV) && (b_data != '0));
    msum    = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : '0);
    rsh     = {w_hi, w_lo[WIDTH-1]};
    ge      = rsh >= {1'b0, opnd};
    rdiff   = rsh[WIDTH-1:0] - opnd;
    if (is_div) begin
      nhi = ge ? rdiff : rsh[WIDTH-1:0];
      nlo = {w_lo[WIDTH-2:0], ge};
    end else begin
      nhi = msum[WIDTH:1];
      nlo = {msum[0], w_lo[WIDTH-1:1]};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      rsp_q     <= '0;
`ifdef ALU_SEQ_MULDIV_EN
      opnd   <= '0;
      w_hi   <= '0;
      w_lo   <= '0;
      cnt    <= '0;
      is_div <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
            if (iter_go) begin
              state  <= BUSY;
              is_div <= (alu_op == OP_DIV);
              opnd   <= (alu_op == OP_DIV) ? b_data : a_data;
              w_lo   <= (alu_op == OP_DIV) ? a_data : b_data;
              w_hi   <= '0;
              cnt    <= '0;
            end else
`endif
            begin
              state     <= DONE;
              out_valid <= 1'b1;
              rsp_q     <= rsp_1c;
            end
          end else begin
            // in_ready lags reset release by one cycle
            in_ready <= 1'b1;
          end
        end
`ifdef ALU_SEQ_MULDIV_EN
        BUSY: begin
          w_hi <= nhi;
          w_lo <= nlo;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            rsp_q     <= '{lo: nlo, hi: nhi, c: 1'b0, ac: 1'b0,
                           ov: (!is_div && (nhi != '0)), err: 1'b0};
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ans    = rsp_q.lo;
  assign ans_hi = rsp_q.hi;
  assign c_out  = rsp_q.c;
  assign ac_out = rsp_q.ac;
  assign ov_out = rsp_q.ov;
  assign err    = rsp_q.err;
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width; legal values are even and at least 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: operation request.
REQ-005 SHALL have port in_ready, output, 1 bit: request accepted when in_valid && in_ready.
REQ-006 SHALL have port alu_op, input, 5 bits: opcode, sampled on accept.
REQ-007 SHALL have ports a_data and b_data, input, WIDTH bits each: operands, sampled on accept.
REQ-008 SHALL have port c_in, input, 1 bit: carry in, sampled on accept.
REQ-009 SHALL have port out_valid, output, 1 bit: result available.
REQ-010 SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready.
REQ-011 SHALL have port ans, output, WIDTH bits: primary result.
REQ-012 SHALL have port ans_hi, output, WIDTH bits: MUL high half or DIV remainder; 0 for all other ops.
REQ-013 SHALL have flag ports c_out, ac_out, ov_out and err, output, 1 bit each.

Function
REQ-014 SHALL decode opcodes: 0 ADD, 1 ADDC, 2 INC(a), 3 DEC(a), 4 SUBB (a-b-c_in), 5 MUL, 6 DIV, 8 ANL, 9 ORL, 10 XRL, 11 CLR, 12 CPL(a), 13 SWAP (exchange halves of a), 14 RL, 15 RLC, 16 RR, 17 RRC.
REQ-015 SHALL treat every other opcode as illegal: ans=0, ans_hi=0, all flags 0 except err=1.
REQ-016 SHALL run the FSM with states IDLE -> (accept) -> BUSY (MUL/DIV only) -> DONE -> (out_valid && out_ready) -> IDLE.
REQ-017 SHALL drive in_ready=1 only in IDLE, and out_valid=1 only in DONE.
REQ-018 SHALL make single-cycle ops enter DONE on the cycle after accept, so out_valid rises 1 cycle after accept.
REQ-019 SHALL compute MUL/DIV iteratively at one bit per cycle in BUSY, so out_valid rises WIDTH+1 cycles after accept.
REQ-020 SHALL hold ans, ans_hi and all flags stable while in DONE until the result is consumed.
REQ-021 ADD/ADDC/SUBB: c_out is the carry/borrow out of the MSB, ac_out the carry/borrow out of bit 3, and ov_out the signed overflow; ADDC adds c_in.
REQ-022 INC/DEC SHALL wrap modulo 2^WIDTH and leave all flags 0.
REQ-023 RLC/RRC SHALL rotate through c_in, with c_out taking the bit shifted out; for all other non-arithmetic ops c_out=0.
REQ-024 MUL SHALL produce {ans_hi,ans}=a*b, with c_out=0 and ov_out=(ans_hi!=0).
REQ-025 DIV SHALL produce ans=a/b and ans_hi=a%b, with c_out=0 and ov_out=0.
REQ-026 DIV with b=0 SHALL skip BUSY, entering DONE after 1 cycle with ans=all-ones, ans_hi=a and ov_out=1.
REQ-027 SHALL ignore in_valid outside IDLE, and SHALL NOT let operand changes after accept affect the result.

Reset
REQ-028 While rst=1, SHALL force: FSM=IDLE, in_ready=0, out_valid=0, ans=0, ans_hi=0, all flags 0.
REQ-029 When rst falls, SHALL raise in_ready on the next cycle.
REQ-030 Reset in BUSY or DONE SHALL abort the operation with no result ever presented.

Configuration
REQ-031 With macro ALU_SEQ_MULDIV_EN defined, opcodes 5 and 6 SHALL behave per REQ-019/024/025/026.
REQ-032 Without ALU_SEQ_MULDIV_EN, opcodes 5 and 6 SHALL be illegal per REQ-015, completing in 1 cycle with no BUSY state or iteration datapath synthesized.

Verification (WIDTH=8)
REQ-033 ADD 0x45,0x26 SHALL give ans=0x6B, c=0, ac=0, ov=0, with out_valid 1 cycle after accept; ADDC 0x75,0x78,c_in=1 SHALL give 0xEE, c=0, ac=0, ov=1.
REQ-034 SUBB 0x57,0x12,c_in=0 SHALL give 0x45, c=0; RLC 0xB2,c_in=1 SHALL give 0x65, c=1; SWAP 0xB2 SHALL give 0x2B.
REQ-035 MUL 0x25,0x04 SHALL give ans=0x94, ans_hi=0x00, ov=0, with out_valid exactly 9 cycles after accept; DIV 0x90,0x0A SHALL give ans=0x0E, ans_hi=0x04.
REQ-036 DIV 0x90,0x00 SHALL give ans=0xFF, ans_hi=0x90, ov=1, with out_valid 1 cycle after accept.
REQ-037 With out_ready=0 for 5 cycles in DONE, outputs SHALL be stable and in_ready=0; new in_valid pulses in that window SHALL be ignored.
REQ-038 rst=1 at cycle 4 of a MUL SHALL give out_valid=0 and all outputs 0, in_ready=1 on the cycle after rst falls, and a following ADD SHALL be correct.
